// File: rtl/vid_seq_pkg.sv
// Shared constants and types for the video slot sequencer.
// Holds default period/slot figures for the MDA-50Hz, MDA-70Hz and CGA
// timings, the default ISA op length, the arbiter state enum and a helper
// that returns the last count at which a grant can still be issued.
package vid_seq_pkg;

  // MDA, 50 Hz refresh (the original fixed 18-cycle character period)
  localparam int MDA50_PERIOD      = 18;
  localparam int MDA50_WIN_END     = 15;
  // MDA, 70 Hz refresh
  localparam int MDA70_PERIOD      = 20;
  localparam int MDA70_WIN_END     = 17;
  // CGA, 16-cycle character period
  localparam int CGA_PERIOD        = 16;
  localparam int CGA_WIN_END       = 13;

  // Slot layout shared by all timings
  localparam int DEF_CW            = 5;
  localparam int DEF_CHARROM_SLOT  = 1;
  localparam int DEF_VRAM_START    = 1;
  localparam int DEF_VRAM_LEN      = 4;
  localparam int DEF_CHAR_SLOT     = 3;
  localparam int DEF_ATT_SLOT      = 4;
  localparam int DEF_PIPE_SLOT     = 4;
  localparam int DEF_ISA_WIN_START = 6;
  localparam int DEF_ISA_OP_CYCLES = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } isa_state_e;

  // Last count at which a grant may be issued for a window ending at win_end.
  function automatic int grant_last(input int win_end, input int op_cycles);
    return win_end - op_cycles + 1;
  endfunction

endpackage

// File: rtl/vid_slot_sequencer_if.sv
// ISA request/grant handshake between the ISA bus bridge and the sequencer.
//   isa_req       bridge -> sequencer  level request, held until granted
//   isa_gnt       sequencer -> bridge  one-cycle grant pulse
//   isa_active    sequencer -> bridge  high while the granted op runs
//   isa_op_enable sequencer -> bridge  count lies inside the safe ISA window
// master modport: ISA bridge side; slave modport: sequencer side.
interface vid_slot_sequencer_if;
  logic isa_req;
  logic isa_gnt;
  logic isa_active;
  logic isa_op_enable;

  modport master (output isa_req, input isa_gnt, isa_active, isa_op_enable);
  modport slave  (input isa_req, output isa_gnt, isa_active, isa_op_enable);
endinterface

// File: rtl/vid_isa_slot_arbiter.sv
// ISA slot arbiter: issues one-cycle grants inside the grant range and times
// the granted op (ISA_OP_CYCLES cycles of isa_active after the grant).
// Optional statistics under macro SEQ_STATS_EN.
// Ports:
//   clk, reset_n         video clock, async active-low reset
//   in_grant_range       count lies where a full op still fits in the window
//   isa_req              level request from the bridge
//   isa_gnt              one-cycle grant (combinational)
//   isa_active           op in progress
//   isa_wait_max [7:0]   (SEQ_STATS_EN) longest request wait, saturating
//   isa_grants  [15:0]   (SEQ_STATS_EN) wrapping grant count
module vid_isa_slot_arbiter
  import vid_seq_pkg::*;
#(
  parameter int ISA_OP_CYCLES = DEF_ISA_OP_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_grant_range,
  input  logic        isa_req,
  output logic        isa_gnt,
  output logic        isa_active
`ifdef SEQ_STATS_EN
  ,
  output logic [7:0]  isa_wait_max,
  output logic [15:0] isa_grants
`endif
);

  localparam int OCW = $clog2(ISA_OP_CYCLES + 1);
  localparam logic [OCW-1:0] OP_LOAD = OCW'(ISA_OP_CYCLES);
  localparam logic [OCW-1:0] OP_ONE  = OCW'(1);

  isa_state_e     state_q, state_d;
  logic [OCW-1:0] op_cnt_q, op_cnt_d;
  logic           gnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_cnt_q <= '0;
      gnt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_cnt_q <= op_cnt_d;
      gnt_q    <= isa_gnt;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_cnt_d   = op_cnt_q;
    isa_active = (state_q == BUSY);
    isa_gnt    = isa_req & ~isa_active & ~gnt_q & in_grant_range;
    case (state_q)
      IDLE: begin
        if (isa_gnt) begin
          state_d  = BUSY;
          op_cnt_d = OP_LOAD;
        end
      end
      BUSY: begin
        if (op_cnt_q == OP_ONE) begin
          state_d  = IDLE;
          op_cnt_d = '0;
        end else begin
          op_cnt_d = op_cnt_q - OP_ONE;
        end
      end
      default: begin
        state_d  = IDLE;
        op_cnt_d = '0;
      end
    endcase
  end

`ifdef SEQ_STATS_EN
  // wait_q counts request-high cycles preceding the grant cycle.
  logic [7:0] wait_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_q       <= '0;
      isa_wait_max <= '0;
      isa_grants   <= '0;
    end else if (isa_gnt) begin
      wait_q     <= '0;
      isa_grants <= isa_grants + 16'd1;
      if (wait_q > isa_wait_max) isa_wait_max <= wait_q;
    end else if (isa_req) begin
      if (wait_q != '1) wait_q <= wait_q + 8'd1;
    end else begin
      wait_q <= '0;
    end
  end
`endif

endmodule

// File: rtl/vid_slot_sequencer.sv
// Character-period slot sequencer for the MDA/CGA video subsystem.
// Divides the video clock into a programmable character period (A or B,
// switched only at wrap), decodes VRAM/char-ROM/pipeline strobes from the
// slot count, and arbitrates ISA VRAM ops into the safe window.
// Optional macro SEQ_STATS_EN adds isa_wait_max/isa_grants outputs.
// Ports:
//   clk, reset_n       video clock, async active-low reset
//   period_sel         0=PERIOD_A, 1=PERIOD_B, sampled at count P-1
//   isa                ISA handshake (slave side)
//   clk_seq            current slot count
//   crtc_clk           pulse at count 0
//   vram_read, vram_read_a0, vram_read_char, vram_read_att,
//   charrom_read, disp_pipeline   slot decodes of the count
//   period_active      latched period select
module vid_slot_sequencer
  import vid_seq_pkg::*;
#(
  parameter int PERIOD_A      = MDA50_PERIOD,
  parameter int PERIOD_B      = MDA70_PERIOD,
  parameter int CW            = DEF_CW,
  parameter int CHARROM_SLOT  = DEF_CHARROM_SLOT,
  parameter int VRAM_START    = DEF_VRAM_START,
  parameter int VRAM_LEN      = DEF_VRAM_LEN,
  parameter int CHAR_SLOT     = DEF_CHAR_SLOT,
  parameter int ATT_SLOT      = DEF_ATT_SLOT,
  parameter int PIPE_SLOT     = DEF_PIPE_SLOT,
  parameter int ISA_WIN_START = DEF_ISA_WIN_START,
  parameter int ISA_WIN_END_A = MDA50_WIN_END,
  parameter int ISA_WIN_END_B = MDA70_WIN_END,
  parameter int ISA_OP_CYCLES = DEF_ISA_OP_CYCLES
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          period_sel,
  vid_slot_sequencer_if.slave isa,
  output logic [CW-1:0] clk_seq,
  output logic          crtc_clk,
  output logic          vram_read,
  output logic          vram_read_a0,
  output logic          vram_read_char,
  output logic          vram_read_att,
  output logic          charrom_read,
  output logic          disp_pipeline,
  output logic          period_active
`ifdef SEQ_STATS_EN
  ,
  output logic [7:0]    isa_wait_max,
  output logic [15:0]   isa_grants
`endif
);

  localparam int MIN_P = (PERIOD_A < PERIOD_B) ? PERIOD_A : PERIOD_B;
  localparam int MAX_P = (PERIOD_A > PERIOD_B) ? PERIOD_A : PERIOD_B;

  if ((2 ** CW) < MAX_P) begin : g_bad_cw
    $error("CW too narrow for the longest period");
  end
  if (CHARROM_SLOT >= MIN_P || VRAM_START + VRAM_LEN - 1 >= MIN_P ||
      CHAR_SLOT >= MIN_P || ATT_SLOT >= MIN_P || PIPE_SLOT >= MIN_P ||
      ISA_WIN_START >= MIN_P) begin : g_bad_slot
    $error("slot parameter outside the shorter period");
  end
  if (ISA_WIN_START <= VRAM_START + VRAM_LEN) begin : g_bad_gap
    $error("ISA window overlaps or abuts the VRAM burst");
  end
  if (ISA_WIN_END_A > PERIOD_A - 2 || ISA_WIN_END_B > PERIOD_B - 2) begin : g_bad_end
    $error("ISA window end too close to period wrap");
  end

  localparam logic [CW-1:0] LAST_A   = CW'(PERIOD_A - 1);
  localparam logic [CW-1:0] LAST_B   = CW'(PERIOD_B - 1);
  localparam logic [CW-1:0] S_CROM   = CW'(CHARROM_SLOT);
  localparam logic [CW-1:0] V_FIRST  = CW'(VRAM_START);
  localparam logic [CW-1:0] V_LAST   = CW'(VRAM_START + VRAM_LEN - 1);
  localparam logic [CW-1:0] S_CHAR   = CW'(CHAR_SLOT);
  localparam logic [CW-1:0] S_ATT    = CW'(ATT_SLOT);
  localparam logic [CW-1:0] S_PIPE   = CW'(PIPE_SLOT);
  localparam logic [CW-1:0] WIN_LO   = CW'(ISA_WIN_START);
  localparam logic [CW-1:0] WIN_HI_A = CW'(ISA_WIN_END_A);
  localparam logic [CW-1:0] WIN_HI_B = CW'(ISA_WIN_END_B);
  localparam logic [CW-1:0] GNT_HI_A = CW'(grant_last(ISA_WIN_END_A, ISA_OP_CYCLES));
  localparam logic [CW-1:0] GNT_HI_B = CW'(grant_last(ISA_WIN_END_B, ISA_OP_CYCLES));

  logic [CW-1:0] count_q;
  logic          period_q;
  logic [CW-1:0] last_cnt, win_end, gnt_hi;
  logic          in_grant_range;

  always_comb begin
    last_cnt = period_q ? LAST_B   : LAST_A;
    win_end  = period_q ? WIN_HI_B : WIN_HI_A;
    gnt_hi   = period_q ? GNT_HI_B : GNT_HI_A;
  end

  // period_sel is only sampled at the wrap, so each period runs full length.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      period_q <= 1'b0;
      crtc_clk <= 1'b0;
    end else if (count_q == last_cnt) begin
      count_q  <= '0;
      period_q <= period_sel;
      crtc_clk <= 1'b1;
    end else begin
      count_q  <= count_q + CW'(1);
      crtc_clk <= 1'b0;
    end
  end

  assign clk_seq           = count_q;
  assign period_active     = period_q;
  assign vram_read         = (count_q >= V_FIRST) && (count_q <= V_LAST);
  assign vram_read_a0      = (count_q == S_CHAR);
  assign vram_read_char    = (count_q == S_CHAR);
  assign vram_read_att     = (count_q == S_ATT);
  assign charrom_read      = (count_q == S_CROM);
  assign disp_pipeline     = (count_q == S_PIPE);
  assign isa.isa_op_enable = (count_q >= WIN_LO) && (count_q <= win_end);
  assign in_grant_range    = (count_q >= WIN_LO) && (count_q <= gnt_hi);

  vid_isa_slot_arbiter #(
    .ISA_OP_CYCLES(ISA_OP_CYCLES)
  ) u_arb (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_grant_range(in_grant_range),
    .isa_req       (isa.isa_req),
    .isa_gnt       (isa.isa_gnt),
    .isa_active    (isa.isa_active)
`ifdef SEQ_STATS_EN
    ,
    .isa_wait_max  (isa_wait_max),
    .isa_grants    (isa_grants)
`endif
  );

endmodule

// File: tb/tb_vid_slot_sequencer.sv
module tb_vid_slot_sequencer;

  localparam int PA = 18, PB = 20, WEA = 15, WEB = 17, WSTART = 6, OPC = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       period_sel = 1'b0;
  logic [4:0] clk_seq;
  logic       crtc_clk, vram_read, vram_read_a0, vram_read_char, vram_read_att;
  logic       charrom_read, disp_pipeline, period_active;
`ifdef SEQ_STATS_EN
  logic [7:0]  isa_wait_max;
  logic [15:0] isa_grants;
`endif

  vid_slot_sequencer_if bus ();

  vid_slot_sequencer #(
    .PERIOD_A(PA),
    .PERIOD_B(PB)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .period_sel    (period_sel),
    .isa           (bus.slave),
    .clk_seq       (clk_seq),
    .crtc_clk      (crtc_clk),
    .vram_read     (vram_read),
    .vram_read_a0  (vram_read_a0),
    .vram_read_char(vram_read_char),
    .vram_read_att (vram_read_att),
    .charrom_read  (charrom_read),
    .disp_pipeline (disp_pipeline),
    .period_active (period_active)
`ifdef SEQ_STATS_EN
    ,
    .isa_wait_max  (isa_wait_max),
    .isa_grants    (isa_grants)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: slot position, period in force, cycles of op remaining.
  int m_cnt = 0, m_per = 0, m_crtc = 0, m_left = 0, m_gprev = 0;

  initial begin
    int p_len, w_end, e_gnt;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_cnt = 0; m_per = 0; m_crtc = 0; m_left = 0; m_gprev = 0;
      end
      p_len = (m_per != 0) ? PB : PA;
      w_end = (m_per != 0) ? WEB : WEA;
      e_gnt = (bus.isa_req && m_left == 0 && m_gprev == 0 &&
               m_cnt >= WSTART && m_cnt + OPC - 1 <= w_end) ? 1 : 0;
      check("clk_seq", int'(clk_seq), m_cnt);
      check("crtc_clk", int'(crtc_clk), m_crtc);
      check("vram_read", int'(vram_read), (m_cnt >= 1 && m_cnt <= 4) ? 1 : 0);
      check("vram_read_a0", int'(vram_read_a0), (m_cnt == 3) ? 1 : 0);
      check("vram_read_char", int'(vram_read_char), (m_cnt == 3) ? 1 : 0);
      check("vram_read_att", int'(vram_read_att), (m_cnt == 4) ? 1 : 0);
      check("charrom_read", int'(charrom_read), (m_cnt == 1) ? 1 : 0);
      check("disp_pipeline", int'(disp_pipeline), (m_cnt == 4) ? 1 : 0);
      check("isa_op_enable", int'(bus.isa_op_enable),
            (m_cnt >= WSTART && m_cnt <= w_end) ? 1 : 0);
      check("period_active", int'(period_active), m_per);
      check("isa_gnt", int'(bus.isa_gnt), e_gnt);
      check("isa_active", int'(bus.isa_active), (m_left > 0) ? 1 : 0);
      if (m_left > 0)
        check("active_in_window", (m_cnt >= WSTART && m_cnt < p_len - 1) ? 1 : 0, 1);
      if (reset_n) begin
        if (m_cnt == p_len - 1) begin
          m_cnt = 0; m_crtc = 1; m_per = int'(period_sel);
        end else begin
          m_cnt++; m_crtc = 0;
        end
        if (e_gnt != 0) m_left = OPC;
        else if (m_left > 0) m_left--;
        m_gprev = e_gnt;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input int v);
    for (int i = 0; i < 45; i++) begin
      if (int'(clk_seq) == v) return;
      step();
    end
    check("wait_for_count", int'(clk_seq), v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g[$];
    int maxc;
    bus.isa_req = 1'b0;
    step(); step();
    check("rst_clk_seq", int'(clk_seq), 0);
    check("rst_crtc", int'(crtc_clk), 0);
    check("rst_active", int'(bus.isa_active), 0);
    check("rst_period", int'(period_active), 0);
    reset_n = 1'b1;

    // Idle for three period-A characters
    repeat (3 * PA) step();

    // Request at count 2: grant at 6, busy at 7..9
    wait_cnt(2);
    bus.isa_req = 1'b1;
    wait_cnt(6); #1;
    check("gnt_at_6", int'(bus.isa_gnt), 1);
    step();
    bus.isa_req = 1'b0;
    check("busy_cnt7", int'(clk_seq), 7);
    check("busy_at_7", int'(bus.isa_active), 1);
    step(); step();
    check("busy_at_9", int'(bus.isa_active), 1);
    step();
    check("idle_at_10", int'(bus.isa_active), 0);

    // Late request at 14: carried to count 6 of next period
    wait_cnt(14);
    bus.isa_req = 1'b1; #1;
    check("no_gnt_at_14", int'(bus.isa_gnt), 0);
    wait_cnt(6); #1;
    check("late_gnt_at_6", int'(bus.isa_gnt), 1);
    step();
    bus.isa_req = 1'b0;

    // Held request across a full period A: grants at 6 and 10
    wait_cnt(0);
    bus.isa_req = 1'b1;
    g.delete();
    for (int i = 0; i < PA; i++) begin
      #1;
      if (bus.isa_gnt) g.push_back(int'(clk_seq));
      step();
    end
    bus.isa_req = 1'b0;
    check("held_A_grants", g.size(), 2);
    if (g.size() == 2) begin
      check("held_A_g0", g[0], 6);
      check("held_A_g1", g[1], 10);
    end

    // Period switch requested mid-period
    wait_cnt(7);
    period_sel = 1'b1;
    wait_cnt(17);
    check("pre_wrap_period", int'(period_active), 0);
    step();
    check("wrap_cnt", int'(clk_seq), 0);
    check("wrap_crtc", int'(crtc_clk), 1);
    check("wrap_period", int'(period_active), 1);

    // Held request across a full period B: grants at 6, 10, 14
    bus.isa_req = 1'b1;
    g.delete();
    maxc = 0;
    for (int i = 0; i < PB; i++) begin
      #1;
      if (bus.isa_gnt) g.push_back(int'(clk_seq));
      if (int'(clk_seq) > maxc) maxc = int'(clk_seq);
      step();
    end
    bus.isa_req = 1'b0;
    check("B_max_count", maxc, 19);
    check("held_B_grants", g.size(), 3);
    if (g.size() == 3) begin
      check("held_B_g0", g[0], 6);
      check("held_B_g1", g[1], 10);
      check("held_B_g2", g[2], 14);
    end

    // Reset in the middle of an op
    period_sel = 1'b0;
    wait_cnt(5);
    bus.isa_req = 1'b1;
    step(); #1;
    check("pre_rst_gnt", int'(bus.isa_gnt), 1);
    step();
    bus.isa_req = 1'b0;
    step();
    check("pre_rst_cnt8", int'(clk_seq), 8);
    check("pre_rst_busy", int'(bus.isa_active), 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_active", int'(bus.isa_active), 0);
    check("rst_mid_cnt", int'(clk_seq), 0);
    check("rst_mid_period", int'(period_active), 0);
    step(); step();
    reset_n = 1'b1;
    bus.isa_req = 1'b1;
    maxc = -1;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (bus.isa_gnt) begin
        maxc = int'(clk_seq);
        break;
      end
      step();
    end
    check("post_rst_gnt_cnt", maxc, 6);
`ifdef SEQ_STATS_EN
    check("post_rst_grants", int'(isa_grants), 0);
`endif
    step();
    bus.isa_req = 1'b0;

    repeat (2 * PA) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
